// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Step counter width for a given operand width
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/div_if.sv
// Request/result bundle between pipeline control and the divider.
// SignedOp exists only when DIV_SIGNED_EN is defined.
interface div_if
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
);

  logic             Start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
`ifdef DIV_SIGNED_EN
  logic             SignedOp;
`endif
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             DivZero;

`ifdef DIV_SIGNED_EN
  modport master (output Start, A, B, SignedOp,
                  input  Busy, Done, Quotient, Remainder, DivZero);
  modport slave  (input  Start, A, B, SignedOp,
                  output Busy, Done, Quotient, Remainder, DivZero);
`else
  modport master (output Start, A, B,
                  input  Busy, Done, Quotient, Remainder, DivZero);
  modport slave  (input  Start, A, B,
                  output Busy, Done, Quotient, Remainder, DivZero);
`endif

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step on {rem, quo}.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  logic             negative;

  // Shift in next dividend bit, trial-subtract, restore on borrow
  always_comb begin
    shifted  = {rem_i, quo_i[WIDTH-1]};
    trial    = shifted - {2'b00, divisor_i};
    negative = trial[WIDTH+1];
    rem_o    = negative ? shifted[WIDTH:0] : trial[WIDTH:0];
    quo_o    = {quo_i[WIDTH-2:0], ~negative};
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring integer divider (quotient -> LO, remainder -> HI).
// Optional signed support selected by the DIV_SIGNED_EN macro.
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic Clk,
  input  logic Rst_n,
  div_if.slave bus
);

  localparam int unsigned CW = cnt_width(WIDTH);

  div_state_e       state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             divzero_q, divzero_d;

  logic             signed_op;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;

`ifdef DIV_SIGNED_EN
  assign signed_op = bus.SignedOp;
`else
  assign signed_op = 1'b0;
`endif

  // Operand magnitudes and sign flags taken at accept
  always_comb begin
    a_neg = signed_op & bus.A[WIDTH-1];
    b_neg = signed_op & bus.B[WIDTH-1];
    a_mag = a_neg ? (~bus.A + WIDTH'(1)) : bus.A;
    b_mag = b_neg ? (~bus.B + WIDTH'(1)) : bus.B;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (div_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  // State and datapath registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      divzero_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      div_q       <= div_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      divzero_q   <= divzero_d;
    end
  end

  // Next-state and datapath control; Done is raised on leaving DONE
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    div_d       = div_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    divzero_d   = divzero_q;

    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          busy_d = 1'b1;
          if (bus.B == '0) begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = bus.A;
            divzero_d   = 1'b1;
          end else begin
            state_d   = CALC;
            rem_d     = '0;
            quo_d     = a_mag;
            div_d     = b_mag;
            cnt_d     = '0;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            divzero_d = 1'b0;
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        if (cnt_q == CW'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FIX: begin
        quotient_d  = neg_quo_q ? (~quo_q + WIDTH'(1)) : quo_q;
        remainder_d = neg_rem_q ? (~rem_q[WIDTH-1:0] + WIDTH'(1)) : rem_q[WIDTH-1:0];
        state_d     = DONE;
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
  assign bus.Quotient  = quotient_q;
  assign bus.Remainder = remainder_q;
  assign bus.DivZero   = divzero_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit (signed cases when DIV_SIGNED_EN is defined).
module tb_div_unit;

  localparam int unsigned W = 32;
  localparam int LAT_NORM = W + 2;
  localparam int LAT_ZERO = 1;

  logic Clk   = 1'b0;
  logic Rst_n = 1'b0;
  logic sgn_unused;

  int total = 0;
  int bad   = 0;

  div_if #(.WIDTH(W)) bus ();

  div_unit #(.WIDTH(W)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Launch one operation and check latency, single Done pulse and results
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sgn, input int exp_lat,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
    int lat;
    lat = -1;
    bus.A = a;
    bus.B = b;
`ifdef DIV_SIGNED_EN
    bus.SignedOp = sgn;
`else
    sgn_unused = sgn;
`endif
    bus.Start = 1'b1;
    @(posedge Clk); #1;
    bus.Start = 1'b0;
    check({tag, ".busy_after_accept"}, 64'(bus.Busy), 64'(1));
    for (int i = 1; i <= 60; i++) begin
      @(posedge Clk); #1;
      if (bus.Done === 1'b1) begin
        lat = i;
        break;
      end
    end
    check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    if (lat > 0) begin
      check({tag, ".busy_in_done"}, 64'(bus.Busy), 64'(0));
      check({tag, ".quotient"}, 64'(bus.Quotient), 64'(eq));
      check({tag, ".remainder"}, 64'(bus.Remainder), 64'(er));
      check({tag, ".divzero"}, 64'(bus.DivZero), 64'(ez));
      @(posedge Clk); #1;
      check({tag, ".done_single"}, 64'(bus.Done), 64'(0));
    end
  endtask

  initial begin
    int done_cnt;
    int first_lat;

    bus.Start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
`ifdef DIV_SIGNED_EN
    bus.SignedOp = 1'b0;
`endif
    sgn_unused = 1'b0;

    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    check("rst.busy", 64'(bus.Busy), 64'(0));
    check("rst.done", 64'(bus.Done), 64'(0));
    check("rst.quotient", 64'(bus.Quotient), 64'(0));
    check("rst.remainder", 64'(bus.Remainder), 64'(0));
    check("rst.divzero", 64'(bus.DivZero), 64'(0));
    Rst_n = 1'b1;
    @(posedge Clk); #1;

    // Unsigned directed vectors
    run_op("u100_7", 32'd100, 32'd7, 1'b0, LAT_NORM, 32'd14, 32'd2, 1'b0);
    run_op("umax_1", 32'hFFFF_FFFF, 32'd1, 1'b0, LAT_NORM, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run_op("u5_9", 32'd5, 32'd9, 1'b0, LAT_NORM, 32'd0, 32'd5, 1'b0);
    run_op("u42_0", 32'd42, 32'd0, 1'b0, LAT_ZERO, 32'hFFFF_FFFF, 32'd42, 1'b1);
    run_op("u20_6", 32'd20, 32'd6, 1'b0, LAT_NORM, 32'd3, 32'd2, 1'b0);
    run_op("umax_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, LAT_NORM, 32'd1, 32'd0, 1'b0);

    // Results hold while idle
    repeat (5) @(posedge Clk);
    #1;
    check("hold.quotient", 64'(bus.Quotient), 64'(1));
    check("hold.remainder", 64'(bus.Remainder), 64'(0));

    // Start re-pulsed while busy must be ignored
    bus.A = 32'd100;
    bus.B = 32'd7;
    bus.Start = 1'b1;
    @(posedge Clk); #1;
    bus.Start = 1'b0;
    done_cnt  = 0;
    first_lat = -1;
    for (int i = 1; i <= 60; i++) begin
      if (i == 10) begin
        bus.A = 32'd50;
        bus.B = 32'd5;
        bus.Start = 1'b1;
      end
      @(posedge Clk); #1;
      bus.Start = 1'b0;
      if (bus.Done === 1'b1) begin
        done_cnt++;
        if (first_lat < 0) first_lat = i;
        check("busy_start.quotient", 64'(bus.Quotient), 64'(14));
        check("busy_start.remainder", 64'(bus.Remainder), 64'(2));
      end
    end
    check("busy_start.done_count", 64'(done_cnt), 64'(1));
    check("busy_start.latency", 64'(first_lat), 64'(LAT_NORM));
    check("busy_start.quotient_after", 64'(bus.Quotient), 64'(14));

    // Asynchronous reset mid-operation
    bus.A = 32'd100;
    bus.B = 32'd7;
    bus.Start = 1'b1;
    @(posedge Clk); #1;
    bus.Start = 1'b0;
    repeat (15) @(posedge Clk);
    #2;
    Rst_n = 1'b0;
    #1;
    check("midrst.busy", 64'(bus.Busy), 64'(0));
    check("midrst.done", 64'(bus.Done), 64'(0));
    check("midrst.quotient", 64'(bus.Quotient), 64'(0));
    check("midrst.remainder", 64'(bus.Remainder), 64'(0));
    check("midrst.divzero", 64'(bus.DivZero), 64'(0));
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 45; i++) begin
      @(posedge Clk); #1;
      if (bus.Done === 1'b1) done_cnt++;
    end
    check("midrst.no_done", 64'(done_cnt), 64'(0));
    run_op("u9_3", 32'd9, 32'd3, 1'b0, LAT_NORM, 32'd3, 32'd0, 1'b0);

`ifdef DIV_SIGNED_EN
    // Signed truncating division
    run_op("s-7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, LAT_NORM, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run_op("s7_-2", 32'd7, 32'hFFFF_FFFE, 1'b1, LAT_NORM, 32'hFFFF_FFFD, 32'd1, 1'b0);
    run_op("smin_-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, LAT_NORM, 32'h8000_0000, 32'd0, 1'b0);
    run_op("s-8_-3", 32'hFFFF_FFF8, 32'hFFFF_FFFD, 1'b1, LAT_NORM, 32'd2, 32'hFFFF_FFFE, 1'b0);
    run_op("u-7_2_unsigned", 32'hFFFF_FFF9, 32'd2, 1'b0, LAT_NORM, 32'h7FFF_FFFC, 32'd1, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
